reset_sequencer: RTL and testbench

Sequences the release of NUM_DOMAINS downstream reset domains in ascending index order after the synchronized system reset deasserts.
- Each domain is released, its ready/ack is awaited with a timeout, then a stagger gap elapses before the next domain.
- Supports a software-requested full re-sequence and reports completion and errors.
- Sits directly after the reset generator in each clock domain.

---
 rtl/reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_reset_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged release of NUM_DOMAINS downstream resets in ascending order after system reset.
// Each domain is released, its ready is awaited with a timeout, then a stagger gap elapses.
module reset_sequencer #(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8,
    localparam int unsigned IDX_WIDTH     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   target_clk,
    input  logic                   target_rst_n,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   seq_error,
    output logic [IDX_WIDTH-1:0]   err_domain
);

    typedef enum logic [2:0] {
        StHold,
        StWaitReady,
        StStagger,
        StDone,
        StError
    } state_e;

    localparam logic [CNT_WIDTH-1:0] HoldLast    = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] StaggerLast = CNT_WIDTH'(STAGGER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] LastIdx     = IDX_WIDTH'(NUM_DOMAINS - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [IDX_WIDTH-1:0]   err_idx_q, err_idx_d;
    logic [IDX_WIDTH-1:0]   lowest_lost;

    // Lowest-index domain whose ready has dropped; scanned high to low so the lowest wins.
    always_comb begin
        lowest_lost = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (!domain_ready[i]) begin
                lowest_lost = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_d     = rst_q;
        err_idx_d = err_idx_q;

        if (sw_rst_req) begin
            state_d   = StHold;
            cnt_d     = '0;
            idx_d     = '0;
            rst_d     = '0;
            err_idx_d = '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (cnt_q == HoldLast) begin
                        rst_d    = '0;
                        rst_d[0] = 1'b1;
                        cnt_d    = '0;
                        idx_d    = '0;
                        state_d  = StWaitReady;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWaitReady: begin
                    if (domain_ready[idx_q]) begin
                        cnt_d   = '0;
                        state_d = (idx_q == LastIdx) ? StDone : StStagger;
                    end else if (cnt_q == TimeoutLast) begin
                        state_d   = StError;
                        err_idx_d = idx_q;
                        rst_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStagger: begin
                    if (cnt_q == StaggerLast) begin
                        idx_d   = idx_q + 1'b1;
                        // Released domains form a thermometer code, so one shift releases idx+1.
                        rst_d   = (rst_q << 1) | NUM_DOMAINS'(1);
                        cnt_d   = '0;
                        state_d = StWaitReady;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (!(&domain_ready)) begin
                        state_d   = StError;
                        err_idx_d = lowest_lost;
                        rst_d     = '0;
                    end
                end
                StError: begin
                    rst_d = '0;
                end
                default: begin
                    state_d   = StHold;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_d     = '0;
                    err_idx_d = '0;
                end
            endcase
        end

        busy_d  = (state_d == StHold) || (state_d == StWaitReady) || (state_d == StStagger);
        done_d  = (state_d == StDone);
        error_d = (state_d == StError);
    end

    always_ff @(posedge target_clk or negedge target_rst_n) begin
        if (!target_rst_n) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_q     <= rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign domain_rst_n = rst_q;
    assign seq_busy     = busy_q;
    assign seq_done     = done_q;
    assign seq_error    = error_q;
    assign err_domain   = err_idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: timing tables plus hand-written corner-case sequences.
module tb_reset_sequencer;

    logic       target_clk = 1'b0;
    logic       target_rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [3:0] domain_ready;
    logic [3:0] domain_rst_n;
    logic       seq_busy;
    logic       seq_done;
    logic       seq_error;
    logic [1:0] err_domain;

    logic [3:0] d1, d2, d3;
    logic       force_mode = 1'b0;
    logic [3:0] force_val = 4'b0000;
    logic [3:0] drop_mask = 4'b0000;

    int checks = 0;
    int failures = 0;
    int rel = 0;

    typedef struct {
        int         seg;
        int         at;
        logic [3:0] rst;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] ed;
    } vec_t;

    vec_t vecs[$];

    reset_sequencer dut (
        .target_clk   (target_clk),
        .target_rst_n (target_rst_n),
        .sw_rst_req   (sw_rst_req),
        .domain_ready (domain_ready),
        .domain_rst_n (domain_rst_n),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .seq_error    (seq_error),
        .err_domain   (err_domain)
    );

    always #5 target_clk = ~target_clk;

    // Ready model: each domain acknowledges 3 cycles after its reset is released.
    always @(posedge target_clk or negedge target_rst_n) begin
        if (!target_rst_n) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            d1 <= domain_rst_n;
            d2 <= d1;
            d3 <= d2;
        end
    end

    assign domain_ready = (force_mode ? force_val : d3) & ~drop_mask;

    function automatic logic [8:0] obs();
        return {domain_rst_n, seq_busy, seq_done, seq_error, err_domain};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got rst/busy/done/err/ed=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge target_clk);
        #1;
    endtask

    // Advance to edge e counted from the last reset deassertion or restart edge.
    task automatic goto_edge(input int e);
        if (e > rel) begin
            tick(e - rel);
            rel = e;
        end
    endtask

    task automatic restart();
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        rel = 0;
    endtask

    task automatic release_reset();
        @(posedge target_clk);
        #1;
        target_rst_n = 1'b1;
        rel = 0;
    endtask

    task automatic run_seg(input int s);
        foreach (vecs[i]) begin
            if (vecs[i].seg == s) begin
                goto_edge(vecs[i].at);
                check($sformatf("seg%0d_edge%0d", s, vecs[i].at), obs(),
                      {vecs[i].rst, vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].ed});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Segment 0: nominal, ready 3 cycles after release.
        vecs.push_back('{0,  0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 15, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 16, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 27, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 28, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 39, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 40, 4'b0111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 51, 4'b0111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 52, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 55, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{0, 56, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0});
        // Segment 1: ready already high before release, qualified one edge after it.
        vecs.push_back('{1, 16, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1, 24, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1, 25, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1, 34, 4'b0111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1, 43, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1, 44, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0});

        #12;
        check("in_reset", obs(), 9'b0000_1_0_0_00);
        release_reset();
        run_seg(0);

        // Timeout on domain 2.
        drop_mask = 4'b0100;
        restart();
        goto_edge(294);
        check("timeout_before", obs(), 9'b0111_1_0_0_00);
        goto_edge(295);
        check("timeout_hit", obs(), 9'b0000_0_0_1_10);
        goto_edge(315);
        check("timeout_held", obs(), 9'b0000_0_0_1_10);
        drop_mask = 4'b0000;

        // Restart out of ERROR, then again mid-STAGGER after domain 1.
        restart();
        check("restart_from_error", obs(), 9'b0000_1_0_0_00);
        goto_edge(34);
        check("stagger_d1", obs(), 9'b0011_1_0_0_00);
        restart();
        check("restart_mid_stagger", obs(), 9'b0000_1_0_0_00);
        goto_edge(15);
        check("rehold_15", obs(), 9'b0000_1_0_0_00);
        goto_edge(16);
        check("rehold_16", obs(), 9'b0001_1_0_0_00);

        // Ready loss in DONE.
        goto_edge(56);
        check("done_again", obs(), 9'b1111_0_1_0_00);
        goto_edge(60);
        drop_mask = 4'b0010;
        tick(1);
        rel = 61;
        drop_mask = 4'b0000;
        check("ready_loss", obs(), 9'b0000_0_0_1_01);
        restart();
        goto_edge(56);
        check("resequence_done", obs(), 9'b1111_0_1_0_00);

        // Restart in the same cycle ready[0] is first sampled high.
        restart();
        goto_edge(19);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        rel = 0;
        check("simul_restart", obs(), 9'b0000_1_0_0_00);
        goto_edge(15);
        check("simul_hold_15", obs(), 9'b0000_1_0_0_00);
        goto_edge(16);
        check("simul_hold_16", obs(), 9'b0001_1_0_0_00);

        // Early ready through a full hardware reset.
        force_mode = 1'b1;
        force_val = 4'b1111;
        target_rst_n = 1'b0;
        #3;
        check("early_in_reset", obs(), 9'b0000_1_0_0_00);
        release_reset();
        run_seg(1);

        // Asynchronous reset between edges while waiting on domain 1.
        force_mode = 1'b0;
        restart();
        goto_edge(30);
        check("pre_async", obs(), 9'b0011_1_0_0_00);
        #3;
        target_rst_n = 1'b0;
        #1;
        check("async_reset", obs(), 9'b0000_1_0_0_00);
        release_reset();
        run_seg(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
